// File: rtl/credit_tx_pkg.sv
// credit_tx_pkg: shared types and constants for the credit-controlled
// CDC transmitter.
//   credit_tx_state_e  - transmitter FSM states (INIT, RUN, DRAIN, DONE)
//   CREDIT_TX_STAT_W   - width of the optional statistics counters
package credit_tx_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } credit_tx_state_e;

  localparam int CREDIT_TX_STAT_W = 32;

endpackage : credit_tx_pkg

// File: rtl/credit_tx_if.sv
// credit_tx_if: handshake bundle around the transmitter.
//   up_valid / up_data / up_ready - upstream valid/ready producer
//   re_valid / data_in            - single-cycle write into the buffer
//   re_credit_pulse               - one pulse per freed buffer slot
// Modports:
//   master - the transmitter side
//   slave  - producer plus buffer side (environment)
interface credit_tx_if #(
  parameter int WIDTH = 32
);

  logic             up_valid;
  logic [WIDTH-1:0] up_data;
  logic             up_ready;
  logic             re_valid;
  logic [WIDTH-1:0] data_in;
  logic             re_credit_pulse;

  modport master (
    input  up_valid,
    input  up_data,
    input  re_credit_pulse,
    output up_ready,
    output re_valid,
    output data_in
  );

  modport slave (
    output up_valid,
    output up_data,
    output re_credit_pulse,
    input  up_ready,
    input  re_valid,
    input  data_in
  );

endinterface : credit_tx_if

// File: rtl/credit_counter.sv
// credit_counter: saturating credit counter preset to DEPTH.
//   clk, rst - clock, synchronous active-high reset
//   inc      - one credit returned this cycle
//   dec      - one credit spent this cycle
//   count    - current credit count (0..DEPTH)
//   err      - sticky: a credit came back while already at DEPTH
module credit_counter #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     dec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= FULL;
      err   <= 1'b0;
    end else if (count == FULL && inc && !dec) begin
      // Spurious return: hold at DEPTH rather than overflow.
      err <= 1'b1;
    end else begin
      count <= count + CW'(inc) - CW'(dec);
    end
  end

endmodule : credit_counter

// File: rtl/credit_tx.sv
// credit_tx: source-side transmitter for the credit-controlled CDC buffer.
// Accepts upstream words, forwards each as a one-cycle write strobe into
// the buffer and tracks the buffer's free slots as credits.
// Ports:
//   re_clk, re_reset - write-domain clock, synchronous active-high reset
//   bus (master)     - upstream handshake, buffer write port, credit pulses
//   drain_req        - stop accepting and wait for all credits to return
//   drained          - all credits home, FSM in DONE
//   credits          - current credit count
//   credit_err       - sticky credit overflow flag
//   stat_sent        - accepted words (0 unless CREDIT_TX_STATS_EN)
//   stat_stall       - credit-starved RUN cycles (0 unless CREDIT_TX_STATS_EN)
// Build option: define CREDIT_TX_STATS_EN to build the statistics counters.
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = 32,
  parameter int INIT_CYCLES = 8
) (
  input  logic                        re_clk,
  input  logic                        re_reset,
  credit_tx_if.master                 bus,
  input  logic                        drain_req,
  output logic                        drained,
  output logic [$clog2(DEPTH):0]      credits,
  output logic                        credit_err,
  output logic [CREDIT_TX_STAT_W-1:0] stat_sent,
  output logic [CREDIT_TX_STAT_W-1:0] stat_stall
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [7:0]    INIT_LAST = 8'(INIT_CYCLES - 1);

  credit_tx_state_e state_q, state_d;
  logic [7:0]       init_cnt_q;
  logic             up_ready;
  logic             accept;
  logic             re_valid_q;
  logic [WIDTH-1:0] data_q;

  // Ready depends on registered state only, never on up_valid or pulses.
  assign up_ready = (state_q == ST_RUN) && (credits != '0);
  assign accept   = bus.up_valid && up_ready;

  assign bus.up_ready = up_ready;
  assign bus.re_valid = re_valid_q;
  assign bus.data_in  = data_q;
  assign drained      = (state_q == ST_DONE);

  credit_counter #(
    .DEPTH (DEPTH)
  ) u_credit_counter (
    .clk   (re_clk),
    .rst   (re_reset),
    .inc   (bus.re_credit_pulse),
    .dec   (accept),
    .count (credits),
    .err   (credit_err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      ST_RUN:   if (drain_req)               state_d = ST_DRAIN;
      ST_DRAIN: if (credits == FULL)         state_d = ST_DONE;
      ST_DONE:  if (!drain_req)              state_d = ST_RUN;
      default:                               state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge re_clk) begin
    if (re_reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT && init_cnt_q != INIT_LAST) begin
        init_cnt_q <= init_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge re_clk) begin
    if (re_reset) begin
      re_valid_q <= 1'b0;
      data_q     <= '0;
    end else begin
      re_valid_q <= accept;
      if (accept) begin
        data_q <= bus.up_data;
      end
    end
  end

`ifdef CREDIT_TX_STATS_EN
  logic [CREDIT_TX_STAT_W-1:0] sent_q, stall_q;

  always_ff @(posedge re_clk) begin
    if (re_reset) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      if (accept) begin
        sent_q <= sent_q + 1'b1;
      end
      if (state_q == ST_RUN && bus.up_valid && credits == '0) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stat_sent  = sent_q;
  assign stat_stall = stall_q;
`else
  assign stat_sent  = '0;
  assign stat_stall = '0;
`endif

endmodule : credit_tx

// File: tb/tb_credit_tx.sv
// tb_credit_tx: directed self-checking bench for credit_tx (DEPTH=16,
// INIT_CYCLES=8). Inputs are driven and outputs sampled 1 ns after each
// rising edge.
module tb_credit_tx;

  logic        re_clk = 1'b0;
  logic        re_reset;
  logic        drain_req;
  logic        drained;
  logic [4:0]  credits;
  logic        credit_err;
  logic [31:0] stat_sent;
  logic [31:0] stat_stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  credit_tx_if #(.WIDTH(32)) bus ();

  credit_tx #(
    .DEPTH       (16),
    .WIDTH       (32),
    .INIT_CYCLES (8)
  ) dut (
    .re_clk     (re_clk),
    .re_reset   (re_reset),
    .bus        (bus),
    .drain_req  (drain_req),
    .drained    (drained),
    .credits    (credits),
    .credit_err (credit_err),
    .stat_sent  (stat_sent),
    .stat_stall (stat_stall)
  );

  always #5 re_clk = ~re_clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge re_clk);
    #1;
  endtask

  initial begin
    re_reset            = 1'b1;
    drain_req           = 1'b0;
    bus.up_valid        = 1'b0;
    bus.up_data         = '0;
    bus.re_credit_pulse = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_credits",  credits,      16);
    check("rst_re_valid", bus.re_valid, 0);
    check("rst_data_in",  bus.data_in,  0);
    check("rst_up_ready", bus.up_ready, 0);
    check("rst_drained",  drained,      0);
    check("rst_err",      credit_err,   0);
    check("rst_sent",     stat_sent,    0);
    check("rst_stall",    stat_stall,   0);

    // Init window, then 16 back-to-back writes
    bus.up_valid = 1'b1;
    bus.up_data  = 32'd100;
    re_reset     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("init_ready", bus.up_ready, 0);
      tick();
    end
    check("run_ready", bus.up_ready, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b2b_valid", bus.re_valid, 1);
      check("b2b_data",  bus.data_in,  100 + i);
      bus.up_data = 32'(101 + i);
    end
    check("empty_credits", credits,      0);
    check("empty_ready",   bus.up_ready, 0);
    tick();
    check("starved_valid",   bus.re_valid, 0);
    check("starved_credits", credits,      0);

    // One credit returned: pending word 116 goes out
    bus.re_credit_pulse = 1'b1;
    tick();
    bus.re_credit_pulse = 1'b0;
    check("ret_credits", credits,      1);
    check("ret_ready",   bus.up_ready, 1);
    check("ret_valid0",  bus.re_valid, 0);
    tick();
    check("ret_valid1",   bus.re_valid, 1);
    check("ret_data",     bus.data_in,  116);
    check("ret_credits0", credits,      0);
    bus.up_valid = 1'b0;
    tick();
    check("ret_valid_end", bus.re_valid, 0);

    // Accept and pulse together at credits=5
    bus.re_credit_pulse = 1'b1;
    repeat (5) tick();
    check("five_credits", credits, 5);
    bus.up_valid = 1'b1;
    bus.up_data  = 32'd300;
    tick();
    bus.up_valid = 1'b0;
    check("same_credits", credits,      5);
    check("same_valid",   bus.re_valid, 1);
    check("same_data",    bus.data_in,  300);
    check("same_err",     credit_err,   0);

    // Fill to 16, then an extra pulse sets the sticky error
    repeat (11) tick();
    bus.re_credit_pulse = 1'b0;
    check("full_credits", credits,    16);
    check("full_err",     credit_err, 0);
    bus.re_credit_pulse = 1'b1;
    tick();
    bus.re_credit_pulse = 1'b0;
    check("ovf_err",     credit_err, 1);
    check("ovf_credits", credits,    16);
    tick();
    check("ovf_sticky",  credit_err, 1);
    check("ovf_hold",    credits,    16);

    // Drain: 4 in flight, drain_req edge still completes a 5th accept
    bus.up_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up_data = 32'(200 + i);
      tick();
    end
    check("pre_drain_credits", credits, 12);
    bus.up_data = 32'd204;
    drain_req   = 1'b1;
    tick();
    check("drain_edge_valid",   bus.re_valid, 1);
    check("drain_edge_data",    bus.data_in,  204);
    check("drain_edge_credits", credits,      11);
    check("drain_ready",        bus.up_ready, 0);
    check("drain_not_done",     drained,      0);
    bus.re_credit_pulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("drain_ready_low", bus.up_ready, 0);
      check("drain_pending",   drained,      0);
    end
    bus.re_credit_pulse = 1'b0;
    check("drain_credits", credits, 16);
    tick();
    check("drained",      drained,      1);
    check("done_ready",   bus.up_ready, 0);
    tick();
    check("done_hold",    drained,      1);
    drain_req    = 1'b0;
    bus.up_valid = 1'b0;
    tick();
    check("rerun_drained", drained,      0);
    check("rerun_ready",   bus.up_ready, 1);

    // Reset mid-burst
    bus.up_valid = 1'b1;
    bus.up_data  = 32'd400;
    tick();
    bus.up_data = 32'd401;
    tick();
    check("burst_valid",   bus.re_valid, 1);
    check("burst_data",    bus.data_in,  401);
    check("burst_credits", credits,      14);
    re_reset = 1'b1;
    tick();
    check("mrst_valid",   bus.re_valid, 0);
    check("mrst_credits", credits,      16);
    check("mrst_err",     credit_err,   0);
    check("mrst_ready",   bus.up_ready, 0);

    // 20 sends over 16 credits with 4 returned credits
    re_reset = 1'b0;
    repeat (8) tick();
    check("st_ready", bus.up_ready, 1);
    repeat (17) tick();
    check("st_empty", credits, 0);
    bus.re_credit_pulse = 1'b1;
    repeat (4) tick();
    bus.re_credit_pulse = 1'b0;
    tick();
    check("st_credits", credits, 0);
    bus.up_valid = 1'b0;
    tick();
`ifdef CREDIT_TX_STATS_EN
    check("stat_sent",  stat_sent,  20);
    check("stat_stall", stat_stall, 2);
`else
    check("stat_sent",  stat_sent,  0);
    check("stat_stall", stat_stall, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_credit_tx

// File: doc/credit_tx.md
# credit_tx

Source-side transmitter for the credit-controlled CDC buffer. Accepts words from an upstream valid/ready producer, forwards them as single-cycle `re_valid`/`data_in` writes into the buffer's receive port, and owns the credit counter. The counter starts at DEPTH, is spent per write, and is replenished by each `re_credit_pulse`. It runs entirely in the buffer's write clock domain and removes the need for any source-side credit logic elsewhere.

## Interface
- `DEPTH`, 16: buffer slots, which is also the initial and maximum credit count.
- `WIDTH`, 32: data word width.
- `INIT_CYCLES`, 8: cycles after reset release before the first word may be accepted (1..255).
- `re_clk`  in  1  write-domain clock.
- `re_reset`  in  1  reset, synchronous, active-high.
- `up_valid`  in  1  upstream word available.
- `up_data`  in  WIDTH  upstream word.
- `up_ready`  out  1  transmitter accepts `up_data` this cycle.
- `re_valid`  out  1  one-cycle write strobe into the buffer.
- `data_in`  out  WIDTH  word written into the buffer.
- `re_credit_pulse`  in  1  one pulse per freed buffer slot.
- `drain_req`  in  1  stop accepting and wait for all credits to return.
- `drained`  out  1  all DEPTH credits are home while in DONE.
- `credits`  out  $clog2(DEPTH)+1  current credit count.
- `credit_err`  out  1  sticky flag for a credit returned while already at DEPTH.
- `stat_sent`  out  32  words sent. Tied to 0 unless stats are compiled in.
- `stat_stall`  out  32  credit-starved cycles. Tied to 0 unless stats are compiled in.

## Operation
- FSM states: INIT, RUN, DRAIN, DONE.
- INIT: an init counter counts to INIT_CYCLES-1, then the FSM moves to RUN.
- RUN: if `drain_req`=1, the FSM moves to DRAIN.
- DRAIN: when `credits`==DEPTH, the FSM moves to DONE.
- DONE: when `drain_req`=0, the FSM moves to RUN.
- `up_ready` = (state==RUN) && (`credits`!=0). It is combinational from registers only and never depends on `up_valid`.
- Accept = `up_valid` && `up_ready`.
  - On accept, `data_in` <= `up_data` and `re_valid` <= 1.
  - Otherwise `re_valid` <= 0 and `data_in` holds its last value.
- Credit update each cycle, with `accept` and `re_credit_pulse` each counting as 0 or 1:
  - If (`credits`==DEPTH && `re_credit_pulse` && !accept), `credit_err` is set and `credits` holds at DEPTH (saturate).
  - Otherwise, next `credits` = `credits` - accept + `re_credit_pulse`.
  - Accept and pulse in the same cycle leave the count unchanged.
- Underflow is impossible because accept requires `credits`!=0.
- `re_credit_pulse` is counted in every state, including INIT and DONE.
- `drained` = (state==DONE).
- `credit_err` clears only on reset.

## Timing
- Reset values:
  - state INIT.
  - `credits`=DEPTH.
  - `re_valid`=0, `data_in`=0, `up_ready`=0.
  - `drained`=0, `credit_err`=0.
  - stats 0.
- Reset is sampled on `re_clk`. Asserting it mid-burst drops any in-flight `re_valid` on the next edge and restores full credits.
- Latency: a word accepted at edge N appears on `re_valid`/`data_in` during cycle N+1 and lasts exactly 1 cycle.
- Throughput is 1 word/cycle while `credits`>0.
- Credit return: a pulse sampled at edge N is visible in `credits` after N. `up_ready` can rise in cycle N+1. There is no combinational pulse-to-ready path.
- First possible accept is INIT_CYCLES cycles after `re_reset` deasserts.
- In RUN, a `drain_req` rising at edge N makes `up_ready` 0 from cycle N+1. An accept at edge N still completes.

## Configuration
- `CREDIT_TX_STATS_EN` defined:
  - `stat_sent` increments on each accept.
  - `stat_stall` increments on each cycle with state==RUN && `up_valid` && `credits`==0.
  - Both wrap modulo 2^32.
- `CREDIT_TX_STATS_EN` undefined: no counters are built, and `stat_sent`/`stat_stall` are constant 0.

## Structure
- `credit_tx_pkg` holds:
  - the state enum `credit_tx_state_e` (INIT, RUN, DRAIN, DONE).
  - the stats width constant `CREDIT_TX_STAT_W`=32.
- Sub-module `credit_counter` contains:
  - the saturating up/down counter with DEPTH preset.
  - the `credit_err` generation.
  - the inputs `inc`, `dec`, with the top level driving `dec` from accept.
- FSM, init counter, output register and stats stay in `credit_tx`.

## Test plan
All scenarios use DEPTH=16.
- Reset then `up_valid`=1 held:
  - `up_ready`=0 for 8 cycles after reset release.
  - Then 16 back-to-back `re_valid` pulses.
  - `credits` reaches 0 and `up_ready`=0.
- Full, then one `re_credit_pulse`: `credits`=1, and the next pending word appears on `re_valid` exactly 2 cycles after the pulse edge.
- `credits`=5, accept and pulse in the same cycle: `credits` stays 5 and `credit_err`=0.
- `credits`=16, pulse with no accept: `credit_err`=1 (sticky), and `credits` stays 16.
- 4 words in flight, assert `drain_req`, return 4 pulses: `up_ready`=0 throughout and `drained`=1 once `credits`=16. Deassert `drain_req`: back to RUN.
- Reset asserted mid-burst: `re_valid`=0 and `credits`=16 next cycle. With `CREDIT_TX_STATS_EN`, a stats check of 20 sends over 16 credits with 4 pulses gives `stat_sent`=20 and `stat_stall`>0.
